// File: rtl/lcm_calc.sv
// lcm_calc: sequential LCM = (in1 / hcf) * in2 using a restoring divider
// followed by a shift-add multiplier, with a start/busy/done handshake.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            request, sampled only while idle
//   in1, in2, hcf    operands and upstream HCF, captured on accepted start
//   busy             high from accept through the final compute cycle
//   done             one-cycle pulse, lcm/err valid
//   lcm              2N-bit result, held until the next accepted start
//   err              hcf was zero or does not divide in1
module lcm_calc #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   in1,
    input  logic [N-1:0]   in2,
    input  logic [N-1:0]   hcf,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] lcm,
    output logic           err
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_MUL,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    q_q, q_d;     // dividend, becomes quotient, then multiplier
    logic [N-1:0]    h_q, h_d;
    logic [N:0]      rem_q, rem_d;
    logic [2*N-1:0]  mc_q, mc_d;   // multiplicand, shifted left each MUL cycle
    logic [2*N-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            bad_q, bad_d; // pending err for the DONE cycle
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [2*N-1:0]  lcm_q, lcm_d;

    logic [N:0]      rem_sh;
    logic            ge;
    logic [N:0]      rem_nx;
    logic [N-1:0]    q_nx;

    // One restoring-division step: shift in the next dividend bit, subtract
    // hcf when it fits. The remainder stays below hcf, so N+1 bits suffice.
    always_comb begin
        rem_sh = {rem_q[N-1:0], q_q[N-1]};
        ge     = (rem_sh >= {1'b0, h_q});
        rem_nx = ge ? (rem_sh - {1'b0, h_q}) : rem_sh;
        q_nx   = (q_q << 1) | N'(ge);
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        h_d     = h_q;
        rem_d   = rem_q;
        mc_d    = mc_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        lcm_d   = lcm_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d    = in1;
                    h_d    = hcf;
                    mc_d   = {{N{1'b0}}, in2};
                    rem_d  = '0;
                    acc_d  = '0;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    busy_d = 1'b1;
                    if (in1 == '0 || in2 == '0) begin
                        bad_d   = 1'b0;
                        state_d = S_DONE;
                    end else if (hcf == '0) begin
                        bad_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        bad_d   = 1'b0;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                rem_d = rem_nx;
                q_d   = q_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rem_nx != '0) begin
                        bad_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (q_q[0]) begin
                    acc_d = acc_q + mc_q;
                end
                mc_d  = mc_q << 1;
                q_d   = q_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Outputs are registered: done/lcm/err appear on the edge
                // that leaves DONE, as the FSM returns to IDLE.
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                err_d   = bad_q;
                lcm_d   = bad_q ? '0 : acc_q;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            h_q     <= '0;
            rem_q   <= '0;
            mc_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lcm_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            h_q     <= h_d;
            rem_q   <= rem_d;
            mc_q    <= mc_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            lcm_q   <= lcm_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign lcm  = lcm_q;

endmodule

// File: tb/tb_lcm_calc.sv
// tb_lcm_calc: directed self-checking bench for lcm_calc (N=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_lcm_calc;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   in1;
    logic [N-1:0]   in2;
    logic [N-1:0]   hcf;
    logic           busy;
    logic           done;
    logic [2*N-1:0] lcm;
    logic           err;

    int checks;
    int failures;

    lcm_calc #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .hcf   (hcf),
        .busy  (busy),
        .done  (done),
        .lcm   (lcm),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse; returns just after the accepting edge k.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] h);
        in1   = a;
        in2   = b;
        hcf   = h;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges after k until done is seen, plus cycles with busy high.
    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        while (!done && cyc < 100) begin
            if (busy) bc++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        hcf   = '0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || lcm !== 16'd0) begin
            failures++;
            $display("FAIL reset busy=%b done=%b err=%b lcm=%0d exp all 0",
                     busy, done, err, lcm);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int cyc, bc;
        start_op(8'd12, 8'd18, 8'd6);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_on got=%b exp=1", busy);
        end
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 17) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=17", cyc);
        end
        checks++;
        if (bc !== 17) begin
            failures++;
            $display("FAIL basic_busy_cycles got=%0d exp=17", bc);
        end
        checks++;
        if (lcm !== 16'd36 || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_result lcm=%0d err=%b exp 36 0", lcm, err);
        end
        tick();
        checks++;
        if (done !== 1'b0 || lcm !== 16'd36) begin
            failures++;
            $display("FAIL basic_pulse done=%b lcm=%0d exp 0 36", done, lcm);
        end
    endtask

    task automatic test_max();
        int cyc, bc;
        start_op(8'd255, 8'd254, 8'd1);
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 17 || lcm !== 16'hFD02 || err !== 1'b0) begin
            failures++;
            $display("FAIL max cyc=%0d lcm=%h err=%b exp 17 fd02 0", cyc, lcm, err);
        end
    endtask

    task automatic test_zero_paths();
        int cyc, bc;
        start_op(8'd0, 8'd5, 8'd5);
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 1 || lcm !== 16'd0 || err !== 1'b0) begin
            failures++;
            $display("FAIL zero_op cyc=%0d lcm=%0d err=%b exp 1 0 0", cyc, lcm, err);
        end
        tick();
        start_op(8'd7, 8'd9, 8'd0);
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 1 || lcm !== 16'd0 || err !== 1'b1) begin
            failures++;
            $display("FAIL zero_hcf cyc=%0d lcm=%0d err=%b exp 1 0 1", cyc, lcm, err);
        end
        tick();
    endtask

    task automatic test_nondiv();
        int cyc, bc;
        start_op(8'd12, 8'd18, 8'd5);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL nondiv_err_clear got=%b exp=0", err);
        end
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 9 || lcm !== 16'd0 || err !== 1'b1) begin
            failures++;
            $display("FAIL nondiv cyc=%0d lcm=%0d err=%b exp 9 0 1", cyc, lcm, err);
        end
        tick();
        checks++;
        if (done !== 1'b0 || err !== 1'b1 || lcm !== 16'd0) begin
            failures++;
            $display("FAIL nondiv_hold done=%b err=%b lcm=%0d exp 0 1 0",
                     done, err, lcm);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc, bc;
        start_op(8'd12, 8'd18, 8'd6);
        in1   = 8'd100;
        in2   = 8'd3;
        hcf   = 8'd7;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        wait_done(cyc, bc);
        checks++;
        if (cyc + 3 !== 17 || lcm !== 16'd36 || err !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore cyc=%0d lcm=%0d err=%b exp 17 36 0",
                     cyc + 3, lcm, err);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int cyc, bc;
        int seen;
        start_op(8'd255, 8'd254, 8'd1);
        repeat (10) tick();
        checks++;
        if (busy !== 1'b1 || lcm !== 16'd36) begin
            failures++;
            $display("FAIL arst_pre busy=%b lcm=%0d exp 1 36", busy, lcm);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || lcm !== 16'd0) begin
            failures++;
            $display("FAIL arst_async busy=%b done=%b err=%b lcm=%0d exp all 0",
                     busy, done, err, lcm);
        end
        tick();
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL arst_no_done got=%0d pulses exp=0", seen);
        end
        start_op(8'd4, 8'd6, 8'd2);
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 17 || lcm !== 16'd12 || err !== 1'b0) begin
            failures++;
            $display("FAIL arst_after cyc=%0d lcm=%0d err=%b exp 17 12 0", cyc, lcm, err);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        int gap;
        in1   = 8'd4;
        in2   = 8'd6;
        hcf   = 8'd2;
        start = 1'b1;
        tick();
        in1 = 8'd9;
        in2 = 8'd6;
        hcf = 8'd3;
        wait_done(cyc, bc);
        checks++;
        if (cyc !== 17 || lcm !== 16'd12) begin
            failures++;
            $display("FAIL b2b_first cyc=%0d lcm=%0d exp 17 12", cyc, lcm);
        end
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!done && gap < 100);
        start = 1'b0;
        checks++;
        if (gap !== 18 || lcm !== 16'd18 || err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second gap=%0d lcm=%0d err=%b exp 18 18 0", gap, lcm, err);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || lcm !== 16'd18) begin
            failures++;
            $display("FAIL b2b_idle busy=%b lcm=%0d exp 0 18", busy, lcm);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_max();
        test_zero_paths();
        test_nondiv();
        test_busy_ignore();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
